// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter: owner ids, order-FIFO entry layout
// and transfer size encodings.
package sram_bus_arbiter_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // One order-FIFO entry: who issued the request and whether its response is stale.
    typedef struct packed {
        logic owner;
        logic cancel;
    } arb_ent_t;

endpackage

// File: rtl/sram_bus_arbiter_order_fifo.sv
// In-order owner FIFO for accepted-but-unanswered requests; a flush marks every
// queued instruction entry as cancelled so its response is later dropped.
module sram_bus_arbiter_order_fifo
    import sram_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push_i,
    input  arb_ent_t push_ent_i,
    input  logic     pop_i,
    input  logic     flush_cancel_i,
    output arb_ent_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    arb_ent_t      ent_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = ent_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + PW'(1);
            if (pop_i && !empty_o) rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_cancel_i && ent_q[i].owner == OWN_INST) ent_q[i].cancel <= 1'b1;
        end
        if (push_i && !full_o) ent_q[wr_q[AW-1:0]] <= push_ent_i;
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between the IF and MEM requesters and steers in-order responses.
// Build option: define ARB_RR_EN for round-robin arbitration (default: fixed data priority).
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int OUTS_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    logic              lock_q, lock_d;
    logic              lk_owner_q, lk_owner_d;
    logic              lk_wr_q, lk_wr_d;
    size_e             lk_size_q, lk_size_d;
    logic [ADDR_W-1:0] lk_addr_q, lk_addr_d;
    logic [DATA_W-1:0] lk_wdata_q, lk_wdata_d;
    logic              lk_cancel_q, lk_cancel_d;

    logic     fifo_full, fifo_empty;
    arb_ent_t head, push_ent;
    logic     owner_free, owner, accept, push_cancel, pop;

`ifdef ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        owner_free = data_req ? OWN_DATA : OWN_INST;
        if (inst_req && data_req) owner_free = ~last_q;
    end

    always_comb begin
        last_d = last_q;
        if (accept) last_d = owner;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= OWN_INST;
        else       last_q <= last_d;
    end
`else
    // Data wins every tie so a stalled MEM stage can never be starved by fetch.
    assign owner_free = data_req ? OWN_DATA : OWN_INST;
`endif

    always_comb begin
        owner   = lock_q ? lk_owner_q : owner_free;
        mem_req = !reset && !fifo_full && (lock_q || inst_req || data_req);

        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            if (lock_q) begin
                mem_wr    = lk_wr_q;
                mem_size  = lk_size_q;
                mem_addr  = lk_addr_q;
                mem_wdata = lk_wdata_q;
            end else if (owner == OWN_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = inst_size;
                mem_addr  = inst_addr;
            end
        end

        accept      = mem_req && mem_addr_ok;
        push_cancel = (owner == OWN_INST) && (flush || lk_cancel_q);
        push_ent.owner  = owner;
        push_ent.cancel = push_cancel;

        inst_addr_ok = accept && (owner == OWN_INST) && !push_cancel;
        data_addr_ok = accept && (owner == OWN_DATA);

        pop          = !reset && mem_data_ok && !fifo_empty;
        data_data_ok = pop && (head.owner == OWN_DATA);
        inst_data_ok = pop && (head.owner == OWN_INST) && !head.cancel && !flush;

        busy       = !reset && (!fifo_empty || lock_q);
        inst_rdata = mem_rdata;
        data_rdata = mem_rdata;
    end

    always_comb begin
        lock_d      = lock_q;
        lk_owner_d  = lk_owner_q;
        lk_wr_d     = lk_wr_q;
        lk_size_d   = lk_size_q;
        lk_addr_d   = lk_addr_q;
        lk_wdata_d  = lk_wdata_q;
        lk_cancel_d = lk_cancel_q;
        if (accept) begin
            lock_d      = 1'b0;
            lk_cancel_d = 1'b0;
        end else if (mem_req) begin
            lock_d = 1'b1;
            if (!lock_q) begin
                lk_owner_d  = owner;
                lk_wr_d     = mem_wr;
                lk_size_d   = size_e'(mem_size);
                lk_addr_d   = mem_addr;
                lk_wdata_d  = mem_wdata;
                lk_cancel_d = flush && (owner == OWN_INST);
            end else begin
                lk_cancel_d = lk_cancel_q || (flush && lk_owner_q == OWN_INST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q      <= 1'b0;
            lk_owner_q  <= OWN_INST;
            lk_wr_q     <= 1'b0;
            lk_size_q   <= SIZE_BYTE;
            lk_addr_q   <= '0;
            lk_wdata_q  <= '0;
            lk_cancel_q <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lk_owner_q  <= lk_owner_d;
            lk_wr_q     <= lk_wr_d;
            lk_size_q   <= lk_size_d;
            lk_addr_q   <= lk_addr_d;
            lk_wdata_q  <= lk_wdata_d;
            lk_cancel_q <= lk_cancel_d;
        end
    end

    sram_bus_arbiter_order_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_order_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_i         (accept),
        .push_ent_i     (push_ent),
        .pop_i          (pop),
        .flush_cancel_i (flush && !reset),
        .head_o         (head),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty)
    );

    // A response with nothing outstanding means the memory side broke protocol.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset) !(mem_data_ok && fifo_empty));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based behavioural model.
module tb_sram_bus_arbiter;

    localparam int  DEPTH = 4;
    localparam bit  INST  = 1'b0;
    localparam bit  DATA  = 1'b1;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OUTS_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of outstanding owners with their stale flags, plus the held request.
    bit          q_own[$];
    bit          q_cxl[$];
    bit          hold_v, hold_own, hold_wr, hold_cxl;
    logic [1:0]  hold_size;
    logic [31:0] hold_addr, hold_wdata;
    bit          last_own = INST;

    always @(negedge clk) begin : cmp
        bit          e_req, e_own, e_wr, e_acc, e_cxl, e_pop, h_own, h_cxl;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;
        if (reset) begin
            chk1("rst_mem_req", mem_req, 1'b0);
            chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
            chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
            chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
            chk1("rst_data_data_ok", data_data_ok, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk32("rst_inst_rdata", inst_rdata, mem_rdata);
            q_own.delete();
            q_cxl.delete();
            hold_v   = 0;
            hold_cxl = 0;
            last_own = INST;
        end else begin
            if (hold_v)                   e_own = hold_own;
            else if (inst_req && data_req)
`ifdef ARB_RR_EN
                                          e_own = !last_own;
`else
                                          e_own = DATA;
`endif
            else                          e_own = data_req ? DATA : INST;
            e_req = (q_own.size() < DEPTH) && (hold_v || inst_req || data_req);
            if (hold_v) begin
                e_wr = hold_wr; e_size = hold_size; e_addr = hold_addr; e_wdata = hold_wdata;
            end else if (e_own == DATA) begin
                e_wr = data_wr; e_size = data_size; e_addr = data_addr; e_wdata = data_wdata;
            end else begin
                e_wr = 0; e_size = inst_size; e_addr = inst_addr; e_wdata = 0;
            end
            e_acc = e_req && mem_addr_ok;
            e_cxl = (e_own == INST) && (flush || hold_cxl);
            e_pop = mem_data_ok && (q_own.size() > 0);
            h_own = e_pop ? q_own[0] : INST;
            h_cxl = e_pop ? q_cxl[0] : 1'b0;

            chk1("mem_req", mem_req, e_req);
            if (e_req) begin
                chk1("mem_wr", mem_wr, e_wr);
                chk32("mem_size", 32'(mem_size), 32'(e_size));
                chk32("mem_addr", mem_addr, e_addr);
                if (e_wr) chk32("mem_wdata", mem_wdata, e_wdata);
            end
            chk1("inst_addr_ok", inst_addr_ok, e_acc && e_own == INST && !e_cxl);
            chk1("data_addr_ok", data_addr_ok, e_acc && e_own == DATA);
            chk1("inst_data_ok", inst_data_ok, e_pop && h_own == INST && !h_cxl && !flush);
            chk1("data_data_ok", data_data_ok, e_pop && h_own == DATA);
            chk1("busy", busy, (q_own.size() > 0) || hold_v);
            chk32("inst_rdata", inst_rdata, mem_rdata);
            chk32("data_rdata", data_rdata, mem_rdata);

            if (e_pop) begin
                void'(q_own.pop_front());
                void'(q_cxl.pop_front());
            end
            if (flush) begin
                foreach (q_own[i]) if (q_own[i] == INST) q_cxl[i] = 1;
                if (hold_v && hold_own == INST) hold_cxl = 1;
            end
            if (e_acc) begin
                q_own.push_back(e_own);
                q_cxl.push_back(e_cxl);
                hold_v   = 0;
                hold_cxl = 0;
                last_own = e_own;
            end else if (e_req && !hold_v) begin
                hold_v = 1; hold_own = e_own; hold_wr = e_wr; hold_size = e_size;
                hold_addr = e_addr; hold_wdata = e_wdata;
                hold_cxl = flush && (e_own == INST);
            end
        end
    end

    task automatic idle();
        flush = 0; inst_req = 0; data_req = 0; data_wr = 0;
        mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
        mem_rdata = $urandom;
    endtask

    initial begin
        reset = 1; idle();
        inst_size = 2'd2; inst_addr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Tie with immediate accept: data first, inst the following cycle.
        next(); inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h0000_2000;
        mem_addr_ok = 1;
        @(negedge clk);
        chk1("t1_data_addr_ok", data_addr_ok, 1'b1);
        chk1("t1_inst_addr_ok", inst_addr_ok, 1'b0);
        chk32("t1_mem_addr", mem_addr, 32'h0000_2000);
        next(); inst_req = 1; mem_addr_ok = 1;
        @(negedge clk);
        chk1("t1_inst_addr_ok2", inst_addr_ok, 1'b1);
        chk32("t1_mem_addr2", mem_addr, 32'h0000_1000);
        next(); mem_data_ok = 1;
        @(negedge clk);
        chk1("t1_rsp1_data", data_data_ok, 1'b1);
        chk1("t1_rsp1_inst", inst_data_ok, 1'b0);
        next(); mem_data_ok = 1;
        @(negedge clk);
        chk1("t1_rsp2_inst", inst_data_ok, 1'b1);

        // Held request: address stays put after the requester drops req.
        next(); inst_req = 1; inst_addr = 32'hbfc0_0000;
        @(negedge clk);
        chk1("t2_mem_req_c1", mem_req, 1'b1);
        next(); inst_addr = 32'h1234_5678;
        @(negedge clk);
        chk32("t2_mem_addr_c2", mem_addr, 32'hbfc0_0000);
        next();
        @(negedge clk);
        chk32("t2_mem_addr_c3", mem_addr, 32'hbfc0_0000);
        next(); mem_addr_ok = 1;
        @(negedge clk);
        chk1("t2_inst_addr_ok", inst_addr_ok, 1'b1);
        chk32("t2_mem_addr_acc", mem_addr, 32'hbfc0_0000);
        next(); mem_data_ok = 1;
        @(negedge clk);
        chk1("t2_inst_data_ok", inst_data_ok, 1'b1);

        // Four outstanding fill the FIFO; a same-cycle pop does not reopen it.
        for (int i = 0; i < 4; i++) begin
            next(); inst_req = 1; inst_addr = 32'h100 * i; mem_addr_ok = 1;
            @(negedge clk);
            chk1("t3_fill_addr_ok", inst_addr_ok, 1'b1);
        end
        next(); inst_req = 1; mem_addr_ok = 1;
        @(negedge clk);
        chk1("t3_full_mem_req", mem_req, 1'b0);
        chk1("t3_full_busy", busy, 1'b1);
        next(); inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        @(negedge clk);
        chk1("t3_full_pop_mem_req", mem_req, 1'b0);
        chk1("t3_full_pop_inst_data_ok", inst_data_ok, 1'b1);
        next(); inst_req = 1; mem_addr_ok = 1;
        @(negedge clk);
        chk1("t3_reopen_addr_ok", inst_addr_ok, 1'b1);
        for (int i = 0; i < 4; i++) begin
            next(); mem_data_ok = 1;
            @(negedge clk);
            chk1("t3_drain_inst_data_ok", inst_data_ok, 1'b1);
        end

        // Flush with inst/data/inst outstanding: only the data response survives.
        next(); inst_req = 1; mem_addr_ok = 1;
        next(); data_req = 1; data_wr = 1; data_wdata = 32'hdead_beef; mem_addr_ok = 1;
        @(negedge clk);
        chk32("t4_mem_wdata", mem_wdata, 32'hdead_beef);
        next(); inst_req = 1; mem_addr_ok = 1;
        next(); flush = 1;
        for (int i = 0; i < 3; i++) begin
            next(); mem_data_ok = 1;
            @(negedge clk);
            chk1("t4_inst_data_ok", inst_data_ok, 1'b0);
            chk1("t4_data_data_ok", data_data_ok, i == 1);
        end

        // Flush coincident with an inst response drops it and still pops.
        next(); inst_req = 1; mem_addr_ok = 1;
        next(); flush = 1; mem_data_ok = 1;
        @(negedge clk);
        chk1("t5_inst_data_ok", inst_data_ok, 1'b0);
        next();
        @(negedge clk);
        chk1("t5_busy_after_pop", busy, 1'b0);

        // Reset with an entry outstanding and a request held discards everything.
        next(); inst_req = 1; mem_addr_ok = 1;
        next(); data_req = 1;
        next(); reset = 1;
        next(); reset = 0;
        @(negedge clk);
        chk1("t7_busy_after_reset", busy, 1'b0);
        chk1("t7_mem_req_after_reset", mem_req, 1'b0);

`ifdef ARB_RR_EN
        // Continuous tie alternates D, I, D, I after reset.
        next(); reset = 1;
        next(); reset = 0;
        for (int i = 0; i < 4; i++) begin
            next(); inst_req = 1; data_req = 1; mem_addr_ok = 1;
            @(negedge clk);
            chk1("t6_rr_data_addr_ok", data_addr_ok, (i % 2) == 0);
            chk1("t6_rr_inst_addr_ok", inst_addr_ok, (i % 2) == 1);
        end
        for (int i = 0; i < 4; i++) begin
            next(); mem_data_ok = 1;
        end
`endif

        // Randomized traffic; responses only while the model has something outstanding.
        for (int n = 0; n < 3000; n++) begin
            next();
            reset       = ($urandom_range(0, 299) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            inst_req    = ($urandom_range(0, 1) == 1);
            inst_size   = 2'($urandom_range(0, 2));
            inst_addr   = $urandom;
            data_req    = ($urandom_range(0, 1) == 1);
            data_wr     = ($urandom_range(0, 1) == 1);
            data_size   = 2'($urandom_range(0, 2));
            data_addr   = $urandom;
            data_wdata  = $urandom;
            mem_addr_ok = ($urandom_range(0, 2) != 0);
            mem_data_ok = (q_own.size() > 0) && ($urandom_range(0, 2) != 0);
        end
        next();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
